count24_disp: RTL

- Display-side consumer of the 24-hour counter's digit outputs (h10, h1).
- Captures the tens/ones hour digits once per scan frame and validates them as hour 00–23.
- Time-multiplexes the two digits onto one common-anode 7-segment bus, with refresh prescaler, optional leading-zero blanking and blink.
- Sits between the hour counter and the board's 2-digit display pins.

---
 rtl/count24_disp.sv | 112 +++++++++++
 1 files changed

// File: rtl/count24_disp.sv
// Two-digit hour display driver: samples h10/h1 once per scan frame, validates 00-23 and
// multiplexes the digits onto a common-anode 7-segment bus with blanking and blink.
module count24_disp #(
  parameter int DIV          = 50000,
  parameter int BLINK_FRAMES = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] h10,
  input  logic [3:0] h1,
  input  logic       blank_lz,
  input  logic       blink_en,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic {ONES = 1'b0, TENS = 1'b1} slot_t;

  slot_t         slot, nslot;
  logic [PW-1:0] pre;
  logic          tick;
  logic [1:0]    h10_q, t10;
  logic [3:0]    h1_q, t1, digit;
  logic          cap, legal, dark;
  logic [BW-1:0] bcnt, bcnt_n;
  logic          phase, phase_n, vis, vis_n;
  logic [6:0]    seg_n;
  logic [1:0]    an_n;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'h40;
      4'd1:    enc = 7'h79;
      4'd2:    enc = 7'h24;
      4'd3:    enc = 7'h30;
      4'd4:    enc = 7'h19;
      4'd5:    enc = 7'h12;
      4'd6:    enc = 7'h02;
      4'd7:    enc = 7'h78;
      4'd8:    enc = 7'h00;
      4'd9:    enc = 7'h10;
      default: enc = 7'h06;
    endcase
  endfunction

  assign tick = (pre == PW'(DIV - 1));

  always_comb begin
    cap   = (slot == ONES);
    nslot = cap ? TENS : ONES;
    // The capture edge displays the freshly sampled digits, not the stale hold registers.
    t10   = cap ? h10 : h10_q;
    t1    = cap ? h1 : h1_q;
    legal = (t10 <= 2'd2) && (t1 <= 4'd9) && !((t10 == 2'd2) && (t1 > 4'd3));

    bcnt_n  = bcnt;
    phase_n = phase;
    vis_n   = vis;
    if (!blink_en) begin
      bcnt_n  = '0;
      phase_n = 1'b1;
      vis_n   = 1'b1;
    end else if (cap) begin
      // vis latches the phase for the whole frame so both slots blink together.
      vis_n = phase;
      if (bcnt == BW'(BLINK_FRAMES - 1)) begin
        bcnt_n  = '0;
        phase_n = ~phase;
      end else begin
        bcnt_n = bcnt + BW'(1);
      end
    end

    digit = (nslot == TENS) ? {2'b00, t10} : t1;
    seg_n = legal ? enc(digit) : 7'h06;
    dark  = ((nslot == TENS) && blank_lz && (t10 == 2'd0) && legal) || (blink_en && !vis_n);
    an_n  = dark ? 2'b11 : ((nslot == TENS) ? 2'b01 : 2'b10);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre   <= '0;
      slot  <= ONES;
      h10_q <= '0;
      h1_q  <= '0;
      bcnt  <= '0;
      phase <= 1'b1;
      vis   <= 1'b1;
      seg   <= 7'h7F;
      an    <= 2'b11;
      err   <= 1'b0;
    end else begin
      pre <= tick ? '0 : pre + PW'(1);
      if (tick) begin
        slot  <= nslot;
        h10_q <= t10;
        h1_q  <= t1;
        bcnt  <= bcnt_n;
        phase <= phase_n;
        vis   <= vis_n;
        seg   <= seg_n;
        an    <= an_n;
        err   <= !legal;
      end
    end
  end

endmodule
